// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment scanner.
package display_scan_ctrl_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        DEAD = 1'b1
    } scan_state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low g..a patterns for hex 0..F; bit7 is overridden by the decimal point.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Host-side shadow write port and frame-aligned update handshake.
interface display_scan_ctrl_if;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic       upd_req;
    logic       upd_ack;

    modport master (
        output wr_en, wr_addr, wr_data, upd_req,
        input  upd_ack
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, upd_req,
        output upd_ack
    );
endinterface

// File: rtl/display_scan_ctrl_seg7.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
module seg7_hex_dec
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] in,
    input  logic       dp,
    output logic [7:0] out
);

    logic [7:0] pattern;

    assign pattern = SEG_TABLE[in];
    assign out     = {~dp, pattern[6:0]};

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans four digits with dead time between them; shadow digits are committed
// to the displayed set only at a frame boundary so a frame never mixes data.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    display_scan_ctrl_if.slave  bus,
    input  logic [3:0]          blank,
    output logic [7:0]          c,
    output logic [3:0]          AN
);

    localparam logic [7:0] DEAD_LAST = 8'(BLANK_CYC - 1);

    scan_state_e      state_q, state_d;
    logic [DIV_W-1:0] on_cnt_q, on_cnt_d;
    logic [7:0]       dead_cnt_q, dead_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][4:0]  shadow_q, shadow_d;
    logic [3:0][4:0]  active_q, active_d;
    logic             pending_q, pending_d;
    logic             upd_ack_q, upd_ack_d;
    logic [7:0]       c_q, c_d;
    logic [3:0]       an_q, an_d;
    logic             commit;
    logic [4:0]       cur_digit;
    logic [7:0]       seg_out;

    assign cur_digit = active_q[idx_q];

    seg7_hex_dec u_dec (
        .in  (cur_digit[3:0]),
        .dp  (cur_digit[4]),
        .out (seg_out)
    );

    always_comb begin
        state_d    = state_q;
        on_cnt_d   = on_cnt_q;
        dead_cnt_d = dead_cnt_q;
        idx_d      = idx_q;
        commit     = 1'b0;
        case (state_q)
            SHOW: begin
                if (on_cnt_q == '1) begin
                    on_cnt_d = '0;
                    state_d  = DEAD;
                end else begin
                    on_cnt_d = on_cnt_q + DIV_W'(1);
                end
            end
            DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    dead_cnt_d = '0;
                    idx_d      = idx_q + 2'd1;
                    state_d    = SHOW;
                    commit     = (idx_q == 2'd3) && pending_q;
                end else begin
                    dead_cnt_d = dead_cnt_q + 8'd1;
                end
            end
            default: state_d = SHOW;
        endcase
    end

    // Commit copies the registered shadow, so a same-edge write lands in shadow only.
    always_comb begin
        shadow_d = shadow_q;
        if (bus.wr_en) begin
            shadow_d[bus.wr_addr] = bus.wr_data;
        end
        active_d  = commit ? shadow_q : active_q;
        pending_d = commit ? bus.upd_req : (pending_q | bus.upd_req);
        upd_ack_d = commit;
    end

    always_comb begin
        an_d = AN_OFF;
        c_d  = SEG_OFF;
        if ((state_q == SHOW) && !blank[idx_q]) begin
            an_d = ~(4'b0001 << idx_q);
            c_d  = seg_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SHOW;
            on_cnt_q   <= '0;
            dead_cnt_q <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            pending_q  <= 1'b0;
            upd_ack_q  <= 1'b0;
            c_q        <= SEG_OFF;
            an_q       <= AN_OFF;
        end else begin
            state_q    <= state_d;
            on_cnt_q   <= on_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            upd_ack_q  <= upd_ack_d;
            c_q        <= c_d;
            an_q       <= an_d;
        end
    end

    assign bus.upd_ack = upd_ack_q;
    assign c           = c_q;
    assign AN          = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: expected per-cycle AN/c and upd_ack cycles are queued up front,
// a monitor compares them against the scanner with DIV_W=2, BLANK_CYC=1 (20-cycle frames).
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] blank;
    logic [7:0] c;
    logic [3:0] an;

    display_scan_ctrl_if bus_if ();

    display_scan_ctrl #(
        .DIV_W     (2),
        .BLANK_CYC (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .blank (blank),
        .c     (c),
        .AN    (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Cycle numbers restart at 1 on the first rising edge after each reset release.
    task automatic pushFrame(input int base, input logic [3:0] bmask,
                             input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] c3, input int last);
        logic [7:0] cv [4];
        exp_t e;
        cv = '{c0, c1, c2, c3};
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 5; s++) begin
                e.cyc = base + 5 * d + s + 1;
                if (s < 4 && !bmask[d]) begin
                    e.an = ~(4'b0001 << d);
                    e.c  = cv[d];
                end else begin
                    e.an = 4'hF;
                    e.c  = 8'hFF;
                end
                if (e.cyc <= last) exp_q.push_back(e);
            end
        end
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int at, input logic we, input logic [1:0] addr,
                                 input logic [4:0] data, input logic req);
        waitCyc(at);
        bus_if.wr_en   = we;
        bus_if.wr_addr = addr;
        bus_if.wr_data = data;
        bus_if.upd_req = req;
        @(negedge clk);
        bus_if.wr_en   = 1'b0;
        bus_if.upd_req = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic exp_ack;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cyc = 0;
            end else begin
                cyc++;
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    failures++;
                    $display("[TB] FAIL missed_scan@%0d: got none expected %h%h", e.cyc, e.an, e.c);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("scan@%0d", cyc), {an, c}, {e.an, e.c});
                end
                exp_ack = (ack_q.size() > 0 && ack_q[0] == cyc);
                if (exp_ack || bus_if.upd_ack) begin
                    checkOutput($sformatf("upd_ack@%0d", cyc), {11'd0, bus_if.upd_ack}, {11'd0, exp_ack});
                end
                if (exp_ack) void'(ack_q.pop_front());
            end
        end
    end

    initial begin
        int guard;
        rst_n          = 1'b1;
        blank          = 4'h0;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_addr = 2'd0;
        bus_if.wr_data = 5'd0;
        bus_if.upd_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_out", {an, c}, 12'hFFF);
        checkOutput("reset_ack", {11'd0, bus_if.upd_ack}, 12'd0);
        repeat (3) @(negedge clk);

        pushFrame(0,   4'h0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1000);
        pushFrame(20,  4'h0, 8'hF9, 8'hA4, 8'hB0, 8'h19, 1000);
        pushFrame(40,  4'h0, 8'h80, 8'h80, 8'h80, 8'h80, 1000);
        pushFrame(60,  4'h4, 8'h80, 8'h80, 8'h80, 8'h80, 1000);
        pushFrame(80,  4'h0, 8'h80, 8'h80, 8'h80, 8'h80, 1000);
        pushFrame(100, 4'h0, 8'h80, 8'h80, 8'h80, 8'h80, 1000);
        pushFrame(120, 4'h0, 8'h92, 8'h80, 8'h80, 8'h80, 134);
        ack_q = '{20, 40, 100, 120};
        rst_n = 1'b1;

        applyStimulus(2, 1'b1, 2'd0, 5'h01, 1'b0);
        applyStimulus(3, 1'b1, 2'd1, 5'h02, 1'b0);
        applyStimulus(4, 1'b1, 2'd2, 5'h03, 1'b0);
        applyStimulus(5, 1'b1, 2'd3, 5'h14, 1'b1);

        for (int d = 0; d < 4; d++) applyStimulus(27 + d, 1'b1, 2'(d), 5'h08, 1'b0);
        applyStimulus(31, 1'b0, 2'd0, 5'h00, 1'b1);

        waitCyc(60);
        blank = 4'b0100;
        waitCyc(80);
        blank = 4'b0000;

        // Pending set earlier, then write + request land exactly on the commit edge.
        applyStimulus(85, 1'b0, 2'd0, 5'h00, 1'b1);
        applyStimulus(99, 1'b1, 2'd0, 5'h05, 1'b1);

        applyStimulus(125, 1'b1, 2'd1, 5'h0A, 1'b0);
        applyStimulus(126, 1'b0, 2'd0, 5'h00, 1'b1);
        waitCyc(134);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_dead_reset_out", {an, c}, 12'hFFF);
        checkOutput("mid_dead_reset_ack", {11'd0, bus_if.upd_ack}, 12'd0);
        repeat (2) @(negedge clk);

        pushFrame(0,   4'h0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1000);
        pushFrame(20,  4'h0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1000);
        pushFrame(40,  4'h0, 8'hC0, 8'h79, 8'hA4, 8'h30, 1000);
        pushFrame(60,  4'h0, 8'h99, 8'h12, 8'h82, 8'h78, 1000);
        pushFrame(80,  4'h0, 8'h80, 8'h10, 8'h88, 8'h03, 1000);
        pushFrame(100, 4'h0, 8'hC6, 8'h21, 8'h86, 8'h0E, 1000);
        ack_q = '{40, 60, 80, 100};
        rst_n = 1'b1;

        for (int j = 0; j < 4; j++) begin
            for (int d = 0; d < 4; d++) begin
                applyStimulus(22 + 20 * j + d, 1'b1, 2'(d), {d[0], 4'(4 * j + d)}, d == 3);
            end
        end

        guard = 0;
        while ((exp_q.size() > 0 || ack_q.size() > 0) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0 || ack_q.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: got %0d scan and %0d ack left expected 0", exp_q.size(), ack_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
